// File: rtl/arm_imm_pkg.sv
// Shared types, widths and the even-rotate helper for the ARM rotated-immediate encoder/decoder.
package arm_imm_pkg;
  localparam int IMM8_W = 8;
  localparam int ROT_W  = 4;
  localparam int WORD_W = 32;
  localparam logic [ROT_W-1:0] ROT_MAX = 4'd15;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Rotate left by 2*r; the doubled word makes the wrap-around a plain shift.
  function automatic logic [WORD_W-1:0] rol_even(input logic [WORD_W-1:0] v,
                                                 input logic [ROT_W-1:0] r);
    logic [2*WORD_W-1:0] d;
    d = {v, v} << {r, 1'b0};
    return d[2*WORD_W-1:WORD_W];
  endfunction
endpackage

// File: rtl/imm_rol_stage.sv
// One search candidate: the word rotated left by 2*r, and whether it fits in imm8.
module imm_rol_stage
  import arm_imm_pkg::*;
(
  input  logic [WORD_W-1:0] val,
  input  logic [ROT_W-1:0]  r,
  output logic [IMM8_W-1:0] imm8,
  output logic              fits8
);
  logic [WORD_W-1:0] cand;

  always_comb begin
    cand  = rol_even(val, r);
    imm8  = cand[IMM8_W-1:0];
    fits8 = (cand[WORD_W-1:IMM8_W] == '0);
  end
endmodule

// File: rtl/imm_rotate_encoder.sv
// Iterative ARM rotated-immediate encoder: tries one rotation per cycle, lowest first.
module imm_rotate_encoder
  import arm_imm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] value,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ROT_W-1:0]  rotate_imm,
  output logic [IMM8_W-1:0] immediate,
  output logic              carry_out
);
  state_t            state;
  logic [WORD_W-1:0] val_q;
  logic              cin_q;
  logic [ROT_W-1:0]  r_q;
  logic [IMM8_W-1:0] imm8;
  logic              fits8;

  imm_rol_stage u_rol (.val(val_q), .r(r_q), .imm8(imm8), .fits8(fits8));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      val_q      <= '0;
      cin_q      <= 1'b0;
      r_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      rotate_imm <= '0;
      immediate  <= '0;
      carry_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            val_q <= value;
            cin_q <= carry_in;
            r_q   <= '0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (fits8) begin
            found      <= 1'b1;
            immediate  <= imm8;
            rotate_imm <= r_q;
            // Unrotated operands pass the C flag through, as the shifter does.
            carry_out  <= (r_q == '0) ? cin_q : val_q[WORD_W-1];
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (r_q == ROT_MAX) begin
            found      <= 1'b0;
            immediate  <= '0;
            rotate_imm <= '0;
            carry_out  <= cin_q;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Directed bench for imm_rotate_encoder: latency, results, busy window, ignored start, reset abort.
module tb_imm_rotate_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        carry_in = 1'b0;
  logic        busy, done, found, carry_out;
  logic [3:0]  rotate_imm;
  logic [7:0]  immediate;

  int checks = 0;
  int errors = 0;

  imm_rotate_encoder dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .carry_in(carry_in),
    .busy(busy), .done(done), .found(found), .rotate_imm(rotate_imm),
    .immediate(immediate), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Launch a request (start high in cycle 0) and return the cycle done appears in.
  task automatic do_search(input logic [31:0] v, input logic c, output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    @(negedge clk);
    value = v; carry_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, found, rotate_imm, immediate, carry_out} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000", {busy, done, found, rotate_imm, immediate, carry_out});
    end
    reset = 1'b0;
  endtask

  task automatic test_encode(input logic [31:0] v, input logic c, input int exp_lat,
                             input logic exp_f, input logic [3:0] exp_r,
                             input logic [7:0] exp_i, input logic exp_c);
    int lat, bb;
    do_search(v, c, lat, bb);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency_%h: got %0d want %0d", v, lat, exp_lat);
    end
    checks++;
    if ({found, rotate_imm, immediate, carry_out} !== {exp_f, exp_r, exp_i, exp_c}) begin
      errors++;
      $display("FAIL result_%h: got f=%b r=%0d imm=%h c=%b want f=%b r=%0d imm=%h c=%b",
               v, found, rotate_imm, immediate, carry_out, exp_f, exp_r, exp_i, exp_c);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL busy_window_%h: got %0d bad cycles want 0", v, bb);
    end
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, found, rotate_imm, immediate, carry_out} !== {1'b0, 1'b0, 1'b1, 4'd4, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL hold: got d=%b b=%b f=%b r=%0d imm=%h c=%b want d=0 b=0 f=1 r=4 imm=ff c=1",
               done, busy, found, rotate_imm, immediate, carry_out);
    end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    int lat = -1;
    @(negedge clk);
    value = 32'h0000FF00; carry_in = 1'b0; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (n == 3) begin
        start = 1'b1; value = 32'h000000FF; carry_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (n == 14) begin
        checks++;
        if ({found, rotate_imm, immediate, carry_out} !== {1'b1, 4'd12, 8'hFF, 1'b0}) begin
          errors++;
          $display("FAIL ignored_start_result: got f=%b r=%0d imm=%h c=%b want f=1 r=12 imm=ff c=0",
                   found, rotate_imm, immediate, carry_out);
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignored_start_pulses: got %0d want 1", ndone);
    end
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL ignored_start_latency: got %0d want 14", lat);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int lat, bb;
    @(negedge clk);
    value = 32'h00000102; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, found, rotate_imm, immediate, carry_out} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want 0000", {busy, done, found, rotate_imm, immediate, carry_out});
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles want 0", ndone);
    end
    do_search(32'h0, 1'b0, lat, bb);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL reset_mid_restart_latency: got %0d want 2", lat);
    end
    checks++;
    if ({found, rotate_imm, immediate} !== {1'b1, 4'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_restart_result: got f=%b r=%0d imm=%h want f=1 r=0 imm=00",
               found, rotate_imm, immediate);
    end
  endtask

  initial begin
    test_reset();
    test_encode(32'h000000FF, 1'b0, 2,  1'b1, 4'd0,  8'hFF, 1'b0);
    test_encode(32'h000000FF, 1'b1, 2,  1'b1, 4'd0,  8'hFF, 1'b1);
    test_encode(32'h00000004, 1'b0, 2,  1'b1, 4'd0,  8'h04, 1'b0);
    test_encode(32'hFF000000, 1'b0, 6,  1'b1, 4'd4,  8'hFF, 1'b1);
    test_hold();
    test_encode(32'hF000000F, 1'b0, 4,  1'b1, 4'd2,  8'hFF, 1'b1);
    test_encode(32'h000003FC, 1'b1, 17, 1'b1, 4'd15, 8'hFF, 1'b0);
    test_encode(32'h00000102, 1'b1, 17, 1'b0, 4'd0,  8'h00, 1'b1);
    test_encode(32'h00000000, 1'b1, 2,  1'b1, 4'd0,  8'h00, 1'b1);
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/imm_rotate_encoder.md
# imm_rotate_encoder

Iterative encoder for the ARM data-processing rotated-immediate format, the inverse of the rotate-immediate decoder. Given a 32-bit constant, it finds the smallest `rotate_imm` (0..15) and the `immediate` (imm8) such that rotating `{24'h0, immediate}` right by `2*rotate_imm` reproduces the constant, or reports that no encoding exists. It sits beside the instruction-assembly/test-vector path and is used to build I-type operand fields. It also reproduces the shifter carry-out the decoder would generate.

## Interface
- No parameters. Widths are fixed by the ISA: value 32, imm8 8, rotate 4.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `value`  in  32  constant to encode; captured when `start` is accepted.
- `carry_in`  in  1  current C flag; captured with `value`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle.
- `found`  out  1  1 = encodable.
- `rotate_imm`  out  4  chosen rotation field.
- `immediate`  out  8  chosen imm8.
- `carry_out`  out  1  shifter carry of the encoded operand.

## Operation
- Registers: `val_q[31:0]`, `cin_q`, `r_q[3:0]`, and the state.
- State IDLE:
  - `start=1` captures `value`/`carry_in`, sets `r_q=0` and moves to SEARCH.
  - `start=0` stays in IDLE.
- State SEARCH, one candidate per cycle:
  - Candidate is `cand = ROL(val_q, 2*r_q)`, a 64-bit-doubling rotate.
  - Match when `cand[31:8]==0`.
  - On match: `found=1`, `immediate=cand[7:0]`, `rotate_imm=r_q`, go to DONE.
  - No match and `r_q==15`: `found=0`, `immediate=0`, `rotate_imm=0`, go to DONE.
  - Otherwise: `r_q=r_q+1`, 4-bit, with no wrap past 15.
- Carry rule, identical to the decoder:
  - `rotate_imm==0` → `carry_out=cin_q`.
  - Otherwise `carry_out=val_q[31]`.
  - Not found → `carry_out=cin_q`.
- State DONE: `done=1` for one cycle, then IDLE unconditionally.
- Result outputs hold their values until the next DONE or until reset.
- Lowest `rotate_imm` wins. Example: `0x00000004` encodes as r=0, imm=0x04, never as a rotated form.
- `value==0` → found, r=0, imm=0x00.
- `start` while in SEARCH or DONE is ignored. No queueing, no effect on the running search.
- Reset values: state IDLE; `busy`, `done`, `found`, `rotate_imm`, `immediate`, `carry_out` all 0; internal registers 0.

## Timing
- Cycle 0 is the cycle `start` is high in IDLE. Edge E1 enters SEARCH with r=0.
- `busy=1` in cycles 1 .. k+1.
- A first match at rotation k gives `done=1` in cycle k+2.
- Latency ranges from 2 cycles (k=0) to 17 cycles (k=15, or not encodable).
- Earliest next accepted `start` is in cycle k+3, once back in IDLE.
- Reset asserted at any edge, including mid-search or in DONE:
  - Next cycle is IDLE with all outputs 0.
  - No `done` is produced for the aborted request.
- Outputs are registered. There is no combinational path from `value` or `start` to any output.

## Structure
- Package `arm_imm_pkg`:
  - State enum `{IDLE, SEARCH, DONE}`.
  - `IMM8_W=8`, `ROT_W=4`, `WORD_W=32`, `ROT_MAX=4'd15`.
  - `rol_even()` function, shared with the decoder's bench model.
- Sub-module `imm_rol_stage`: combinational `cand = ROL(val, 2*r)` plus the `fits8` flag. This is the only natural split; the FSM and result registers stay in the top module.

## Test plan
- `value=0x000000FF`, `carry_in=0` → `done` in cycle 2; found=1, r=0, imm=0xFF, carry_out=0.
- `value=0xFF000000` → `done` in cycle 6; found=1, r=4, imm=0xFF, carry_out=1.
- `value=0xF000000F` → found=1, r=2, imm=0xFF, carry_out=1. `value=0x000003FC` → found=1, r=15, imm=0xFF, carry_out=0, `done` in cycle 17.
- `value=0x00000102`, `carry_in=1` → `done` in cycle 17; found=0, r=0, imm=0, carry_out=1. `busy` is high in cycles 1–16.
- `start` pulsed again in cycle 3 of a search for `0x0000FF00` → ignored. The first result is r=12, imm=0xFF, and exactly one `done` pulse occurs.
- `reset` asserted in cycle 5 of a `0x00000102` search → IDLE next cycle, all outputs 0, no `done`. A fresh `start` with `0x0` then gives found=1, r=0, imm=0 in cycle 2.
